// File: rtl/ifetch_prefetch.sv
// Instruction-fetch front end: drives the synchronous ROM, buffers returned words with their PCs
// and hands them to decode over valid/ready. Optional IFETCH_BYPASS_EN forwards a returning word straight to decode.
module ifetch_prefetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   output logic [31:0] o_imem_addr,
   input  logic [31:0] i_imem_data,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic [31:0] o_instr,
   output logic [31:0] o_pc,
   output logic        o_valid,
   input  logic        i_ready
);

   localparam int unsigned AW      = $clog2(DEPTH);
   localparam int unsigned CW      = AW + 1;
   localparam logic [CW:0]   DEPTH_V = (CW + 1)'(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(32'd1);
   localparam logic [CW-1:0] CNT_ONE = CW'(32'd1);

   logic [31:0]   fetch_pc_r;
   logic [31:0]   req_pc_r;
   logic          inflight_r;
   logic [CW-1:0] count_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW-1:0] wr_ptr_r;
   logic [31:0]   instr_mem_r [DEPTH];
   logic [31:0]   pc_mem_r    [DEPTH];

   logic          empty_s;
   logic          byp_s;
   logic          byp_take_s;
   logic          pop_s;
   logic          push_s;
   logic          issue_s;
   logic [CW:0]   occ_s;

   assign o_imem_addr = fetch_pc_r;

   // Handshake, bypass and issue decisions for the current cycle.
   always_comb begin
      empty_s = (count_r == {CW{1'b0}});
`ifdef IFETCH_BYPASS_EN
      byp_s = empty_s && inflight_r && !i_redirect;
`else
      byp_s = 1'b0;
`endif
      byp_take_s = byp_s && i_ready;
      pop_s      = !empty_s && i_ready && !i_redirect;
      push_s     = inflight_r && !i_redirect && !byp_take_s;
      // Occupancy once this cycle settles; a consumed bypass word never takes a slot.
      occ_s      = {1'b0, count_r} + {{CW{1'b0}}, inflight_r}
                 - {{CW{1'b0}}, pop_s} - {{CW{1'b0}}, byp_take_s};
      issue_s    = !i_redirect && (occ_s < DEPTH_V);
      o_valid    = !i_redirect && (!empty_s || byp_s);
      if (byp_s) begin
         o_instr = i_imem_data;
         o_pc    = req_pc_r;
      end else begin
         o_instr = instr_mem_r[rd_ptr_r];
         o_pc    = pc_mem_r[rd_ptr_r];
      end
   end

   // Fetch PC, in-flight tracking and FIFO state; redirect overrides push, pop and issue.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         fetch_pc_r <= RESET_PC;
         req_pc_r   <= 32'h0000_0000;
         inflight_r <= 1'b0;
         count_r    <= {CW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         wr_ptr_r   <= {AW{1'b0}};
         for (int unsigned i = 0; i < DEPTH; i++) begin
            instr_mem_r[i] <= 32'h0000_0000;
            pc_mem_r[i]    <= 32'h0000_0000;
         end
      end else if (i_redirect) begin
         fetch_pc_r <= i_redirect_pc & 32'hFFFF_FFFC;
         inflight_r <= 1'b0;
         count_r    <= {CW{1'b0}};
         rd_ptr_r   <= {AW{1'b0}};
         wr_ptr_r   <= {AW{1'b0}};
      end else begin
         if (issue_s) begin
            inflight_r <= 1'b1;
            req_pc_r   <= fetch_pc_r;
            fetch_pc_r <= fetch_pc_r + 32'd4;
         end else begin
            inflight_r <= 1'b0;
         end
         if (push_s) begin
            instr_mem_r[wr_ptr_r] <= i_imem_data;
            pc_mem_r[wr_ptr_r]    <= req_pc_r;
            wr_ptr_r              <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + CNT_ONE;
            2'b01:   count_r <= count_r - CNT_ONE;
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: tb/tb_ifetch_prefetch.sv
// Self-checking bench for ifetch_prefetch: ROM model returns word[n]=n, a queue holds the PCs
// expected after each reset/redirect and is popped on every accepted handshake.
module tb_ifetch_prefetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam int unsigned DEPTH    = 4;
`ifdef IFETCH_BYPASS_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 3;
`endif

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic [31:0] o_imem_addr;
   logic [31:0] i_imem_data;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic [31:0] o_instr;
   logic [31:0] o_pc;
   logic        o_valid;
   logic        i_ready;

   int          checks   = 0;
   int          failures = 0;
   int          deliv    = 0;
   logic [31:0] exp_q [$];
   logic        s_valid;
   logic [31:0] s_addr;
   logic [31:0] s_pc;
   logic [31:0] s_instr;

   ifetch_prefetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .o_imem_addr  (o_imem_addr),
      .i_imem_data  (i_imem_data),
      .i_redirect   (i_redirect),
      .i_redirect_pc(i_redirect_pc),
      .o_instr      (o_instr),
      .o_pc         (o_pc),
      .o_valid      (o_valid),
      .i_ready      (i_ready)
   );

   always #5 i_clk = ~i_clk;

   function automatic logic [31:0] rom_word(input logic [31:0] addr);
      return {2'b00, addr[31:2]};
   endfunction

   // Synchronous ROM with one cycle of read latency.
   always @(posedge i_clk) i_imem_data <= rom_word(o_imem_addr);

   task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
      end
   endtask

   task automatic load_exp(input logic [31:0] start);
      logic [31:0] p;
      p = start;
      exp_q.delete();
      deliv = 0;
      for (int i = 0; i < 64; i++) begin
         exp_q.push_back(p);
         p = p + 32'd4;
      end
   endtask

   // One clock: sample mid-cycle, score any accepted handshake, return just after the edge.
   task automatic tick();
      logic [31:0] e;
      @(negedge i_clk);
      s_valid = o_valid;
      s_addr  = o_imem_addr;
      s_pc    = o_pc;
      s_instr = o_instr;
      if (i_rst_n && o_valid && i_ready && !i_redirect) begin
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk_eq("pc", o_pc, e);
            chk_eq("instr", o_instr, rom_word(e));
            deliv++;
         end else begin
            chk_eq("spurious_valid", {31'b0, o_valid}, 32'd0);
         end
      end
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst_n    = 1'b0;
      i_redirect = 1'b0;
      tick();
      tick();
      chk_eq("rst_valid", {31'b0, s_valid}, 32'd0);
      chk_eq("rst_instr", s_instr, 32'd0);
      chk_eq("rst_pc", s_pc, 32'd0);
      chk_eq("rst_addr", s_addr, RESET_PC);
      i_rst_n = 1'b1;
      load_exp(RESET_PC);
   endtask

   task automatic redir(input logic [31:0] pc);
      i_redirect    = 1'b1;
      i_redirect_pc = pc;
      tick();
      chk_eq("redir_valid", {31'b0, s_valid}, 32'd0);
      i_redirect = 1'b0;
      load_exp(pc & 32'hFFFF_FFFC);
   endtask

   task automatic wait_first_valid(input string tag);
      int k;
      k = 0;
      do begin
         tick();
         k++;
      end while (!s_valid && k < 20);
      chk_eq(tag, 32'(k), 32'(LAT));
   endtask

   initial begin
      i_rst_n       = 1'b0;
      i_redirect    = 1'b0;
      i_redirect_pc = 32'd0;
      i_ready       = 1'b1;

      // Startup: address sequence, first-valid latency, gapless stream.
      do_reset();
      for (int c = 1; c <= 5; c++) begin
         tick();
         chk_eq("addr_seq", s_addr, RESET_PC + 32'(4 * (c - 1)));
         chk_eq("valid_seq", {31'b0, s_valid}, 32'(c >= LAT));
      end
      for (int c = 0; c < 8; c++) begin
         tick();
         chk_eq("no_gap", {31'b0, s_valid}, 32'd1);
      end
      chk_eq("t1_deliv", 32'(deliv), 32'(14 - LAT));

      // Backpressure from reset: exactly DEPTH words buffered, fetch stalls.
      i_ready = 1'b0;
      do_reset();
      for (int c = 1; c <= 12; c++) begin
         tick();
         if (c >= 6) chk_eq("stall_addr", s_addr, RESET_PC + 32'(4 * DEPTH));
      end
      chk_eq("full_valid", {31'b0, s_valid}, 32'd1);
      chk_eq("full_head", s_pc, RESET_PC);
      i_ready = 1'b1;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk_eq("drain_valid", {31'b0, s_valid}, 32'd1);
      end
      chk_eq("t2_deliv", 32'(deliv), 32'd5);

      // Redirect with three buffered words and one read in flight.
      i_ready = 1'b0;
      do_reset();
      repeat (4) tick();
      redir(32'h0000_0100);
      i_ready = 1'b1;
      wait_first_valid("lat_100");
      repeat (3) tick();
      chk_eq("t3_deliv", 32'(deliv), 32'd4);

      // Misaligned target, then back-to-back redirects.
      redir(32'h0000_0203);
      wait_first_valid("lat_203");
      repeat (2) tick();
      chk_eq("t4a_deliv", 32'(deliv), 32'd3);
      redir(32'h0000_0040);
      redir(32'h0000_0080);
      wait_first_valid("lat_080");
      repeat (2) tick();
      chk_eq("t4b_deliv", 32'(deliv), 32'd3);

      // PC wrap at the top of the address space.
      redir(32'hFFFF_FFF8);
      wait_first_valid("lat_wrap");
      repeat (3) tick();
      chk_eq("t5_deliv", 32'(deliv), 32'd4);

      // Reset while the FIFO is full.
      i_ready = 1'b0;
      repeat (10) tick();
      chk_eq("pre_rst_full", {31'b0, s_valid}, 32'd1);
      do_reset();
      i_ready = 1'b1;
      wait_first_valid("lat_rst");
      repeat (3) tick();
      chk_eq("t6_deliv", 32'(deliv), 32'd4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ifetch_prefetch.md
Name: ifetch_prefetch

Overview:
- Instruction-fetch front end. Drives the byte address into the synchronous 64 KiB instruction ROM and accepts that ROM's 1-cycle-latency read data.
- Buffers returned words with their PCs in a small FIFO and presents them to decode over a valid/ready handshake.
- Handles pipeline redirects (branch/jump/trap): flushes buffered words, discards any in-flight read, and restarts fetch at the new PC.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 4, FIFO entries; power of two, ≥ 2.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- o_imem_addr  output  32  byte address to instruction ROM; combinational from fetch PC register.
- i_imem_data  input  32  ROM read data; corresponds to the o_imem_addr presented on the previous edge.
- i_redirect  input  1  flush and restart request.
- i_redirect_pc  input  32  new fetch PC; bits [1:0] ignored and forced to 0.
- o_instr  output  32  instruction at FIFO head.
- o_pc  output  32  PC of o_instr.
- o_valid  output  1  head entry valid.
- i_ready  input  1  decode accepts head this cycle.

Behaviour:
- Reset (i_rst_n=0 at edge):
  - fetch_pc = RESET_PC; FIFO empty (count=0, pointers 0); inflight=0.
  - o_valid=0, o_instr=0, o_pc=0.
  - o_imem_addr = RESET_PC during and after reset.
- Pop: o_valid && i_ready && !i_redirect. Head advances at the edge.
- Issue condition: (count − pop + inflight) < DEPTH, with no redirect this cycle.
  - On issue: inflight<=1, req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (32-bit wrap, 0xFFFF_FFFC → 0x0000_0000).
  - Otherwise: inflight<=0, fetch_pc holds.
  - The ROM reads every cycle; non-issued reads are simply ignored.
- Push: if inflight==1, {i_imem_data, req_pc} is written at the tail this edge. Space is guaranteed by the issue condition. Push and pop in the same cycle leave count unchanged.
- Redirect (i_redirect=1):
  - o_valid is forced 0 combinationally; no pop, no push.
  - FIFO is emptied, inflight<=0 (the returning word is dropped), fetch_pc<=i_redirect_pc & ~3.
  - Redirect has priority over every other event, including push/pop on the same edge.
  - Consecutive redirects: the last one wins.
- Steady-state latency (no bypass): the cycle after reset release issues the RESET_PC read. Data returns the next cycle, is pushed on that edge, and o_valid=1 the following cycle. Redirect-to-valid is 3 cycles.
- Throughput: with i_ready held 1, one instruction per cycle sustained after fill.
- Backpressure: with i_ready=0, FIFO fills to DEPTH exactly. Issue stops with inflight counted; no word is ever lost or overwritten.
- FIFO contents are registered. o_instr/o_pc reflect the head entry; they are unspecified-but-stable when o_valid=0, and 0 after reset.
- count width is clog2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Reset mid-operation behaves identically to a power-on reset; in-flight data is discarded.

Optional Feature:
- Macro: IFETCH_BYPASS_EN.
- Defined: when the FIFO is empty, inflight==1 and no redirect, the returning word is presented combinationally on o_instr/o_pc with o_valid=1.
  - If i_ready=1, it is consumed without being written to the FIFO.
  - If i_ready=0, it is pushed normally.
  - Redirect-to-valid becomes 2 cycles.
  - The issue condition counts a bypassed word as popped.
- Undefined: no bypass path; all words traverse the FIFO (latency as above).

Test Plan:
- Reset release with RESET_PC=0, ROM word[n]=n, i_ready=1 -> o_imem_addr 0,4,8,…; o_valid first high 3 cycles after reset release (2 with bypass); o_pc/o_instr sequence (0,0),(4,1),(8,2) with no gaps.
- i_ready=0 for 10 cycles after fill, DEPTH=4 -> exactly 4 entries buffered; o_imem_addr stops advancing; on i_ready=1, PCs 0,4,8,12,16 delivered in order with no duplicates or skips.
- Redirect to 0x100 while FIFO holds 3 entries and a read is in flight -> o_valid=0 in redirect cycle; next delivered o_pc=0x100, instr=word[0x40]; no pre-redirect word appears.
- Redirect with i_redirect_pc=0x203 -> fetch resumes at 0x200; back-to-back redirects 0x40 then 0x80 -> first delivered o_pc=0x80.
- fetch_pc=0xFFFF_FFF8, i_ready=1 -> delivered PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Assert i_rst_n=0 mid-stream with FIFO full -> next edge o_valid=0, count=0; fetch restarts at RESET_PC; no stale words delivered.
